// File: rtl/mbist_mem_arbiter.sv
// Arbitrates the single-port test memory between the host port and the MBIST controller.
// Optional BIST ownership timeout with sticky bist_abort: define MBIST_ARB_TIMEOUT_EN.
module mbist_mem_arbiter #(
    parameter int unsigned addr    = 3,
    parameter int unsigned data    = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            h_req,
    input  logic            h_we,
    input  logic [addr-1:0] h_addr,
    input  logic [data-1:0] h_wdata,
    output logic            h_gnt,
    output logic            h_rvalid,
    output logic [data-1:0] h_rdata,
    input  logic            bist_req,
    output logic            bist_gnt,
    input  logic            b_read,
    input  logic            b_write,
    input  logic [addr-1:0] b_addr,
    input  logic [data-1:0] b_din,
    output logic [data-1:0] b_dout,
    output logic            bist_conflict,
    output logic            mem_read,
    output logic            mem_write,
    output logic [addr-1:0] mem_addr,
    output logic [data-1:0] mem_din,
    input  logic [data-1:0] mem_dout
`ifdef MBIST_ARB_TIMEOUT_EN
    ,
    output logic            bist_abort
`endif
);

    localparam int unsigned AW = addr;
    localparam int unsigned DW = data;

    typedef enum logic [1:0] {
        ST_HOST    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_BIST    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            hv_q;
    logic            hwe_q;
    logic            rv_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;
    logic            in_bist;
    logic            drained;
    logic            eff_req;
    logic            to_hit;

    assign in_bist = (state == ST_BIST);
    // Drained once nothing is issued to memory and no read data is still owed to the host.
    assign drained = ~hv_q & ~rv_q;

`ifdef MBIST_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] to_cnt;

    assign eff_req = bist_req & ~bist_abort;
    assign to_hit  = in_bist && (to_cnt == CW'(TIMEOUT - 1));

    // Ownership counter: zero outside BIST so it restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt     <= '0;
            bist_abort <= 1'b0;
        end else begin
            to_cnt <= in_bist ? to_cnt + CW'(1) : '0;
            if (to_hit) begin
                bist_abort <= 1'b1;
            end
        end
    end
`else
    assign eff_req = bist_req;
    assign to_hit  = 1'b0;

    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_HOST;
            hv_q          <= 1'b0;
            hwe_q         <= 1'b0;
            rv_q          <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            bist_conflict <= 1'b0;
        end else begin
            state <= state_nx;
            hv_q  <= h_gnt;
            rv_q  <= hv_q & ~hwe_q;
            if (h_gnt) begin
                hwe_q  <= h_we;
                addr_q <= h_addr;
                din_q  <= h_wdata;
            end
            bist_conflict <= bist_conflict | (in_bist & b_read & b_write);
        end
    end

    // Next state and memory pin mux; host pipeline drives the pins except in BIST.
    always_comb begin
        state_nx  = state;
        h_gnt     = 1'b0;
        bist_gnt  = 1'b0;
        mem_read  = hv_q & ~hwe_q;
        mem_write = hv_q & hwe_q;
        mem_addr  = addr_q;
        mem_din   = din_q;
        case (state)
            ST_HOST: begin
                h_gnt = h_req & ~eff_req & ~rst;
                if (eff_req) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!eff_req) begin
                    state_nx = ST_HOST;
                end else if (drained) begin
                    state_nx = ST_BIST;
                end
            end
            ST_BIST: begin
                bist_gnt  = 1'b1;
                mem_read  = b_read & ~b_write;
                mem_write = b_write;
                mem_addr  = b_addr;
                mem_din   = b_din;
                if (to_hit || !bist_req) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                state_nx  = ST_HOST;
            end
            default: begin
                state_nx = ST_HOST;
            end
        endcase
    end

    assign h_rvalid = rv_q;
    assign h_rdata  = rv_q ? mem_dout : '0;
    assign b_dout   = mem_dout;

endmodule
